// File: rtl/ps2_scancode_decoder.sv
// PS/2 keyboard receiver: synchronizes ps2_clk/ps2_data, deframes bytes, applies E0/F0/E1 prefix rules.
// Optional macro PS2_PARITY_CHECK_EN rejects frames with bad odd parity; default build ignores the parity bit.
module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] keyCode,
  output logic       make,
  output logic       brake,
  output logic       parity_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;
  logic                   w_par_ok;

  state_t      r_state;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [15:0] r_idle_cnt;
  logic [7:0]  r_byte;
  logic        r_byte_vld;
  logic        r_err_vld;
  logic        r_tmo;

  logic        r_ext;
  logic        r_brk;
  logic [8:0]  r_key_code;
  logic        r_make;
  logic        r_brake;
  logic        r_perr;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;

`ifdef PS2_PARITY_CHECK_EN
  logic r_par;
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  // Lines reset to 1 so a reset never looks like a falling edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= w_clk_s;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_idle_cnt <= '0;
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
      r_err_vld  <= 1'b0;
      r_tmo      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_byte_vld <= 1'b0;
      r_err_vld  <= 1'b0;
      r_tmo      <= 1'b0;
      if (w_fall) begin
        r_idle_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!w_dat_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_par <= w_dat_s;
`endif
            r_state <= S_STOP;
          end
          S_STOP: begin
            if (w_dat_s && w_par_ok) begin
              r_byte     <= r_shift;
              r_byte_vld <= 1'b1;
            end else begin
              r_err_vld  <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_idle_cnt == TMO_LAST) begin
          r_state    <= S_IDLE;
          r_tmo      <= 1'b1;
          r_idle_cnt <= '0;
          r_bit_cnt  <= '0;
          r_shift    <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 16'd1;
        end
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

  // Prefix layer: one cycle after byte delivery, giving the N+2 output timing.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_key_code <= 9'h000;
      r_make     <= 1'b0;
      r_brake    <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_make  <= 1'b0;
      r_brake <= 1'b0;
      r_perr  <= 1'b0;
      if (r_err_vld) begin
        r_perr <= 1'b1;
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
      end else if (r_tmo) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_byte_vld) begin
        case (r_byte)
          8'hE0: r_ext <= 1'b1;
          8'hF0: r_brk <= 1'b1;
          8'hE1: ;
          default: begin
            r_key_code <= {r_ext, r_byte};
            r_make     <= ~r_brk;
            r_brake    <= r_brk;
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign keyCode    = r_key_code;
  assign make       = r_make;
  assign brake      = r_brake;
  assign parity_err = r_perr;

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on ps2_clk and ps2_data.
REQ-003 SHALL have port clk, input, 1, system clock; the block uses this single clock only.
REQ-004 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1, raw PS/2 clock line, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1, raw PS/2 data line, asynchronous to clk.
REQ-007 SHALL have port keyCode, output, 9, bit 8 = extended (E0) flag, bits 7:0 = scan code.
REQ-008 SHALL have port make, output, 1, one-cycle pulse for a key press.
REQ-009 SHALL have port brake, output, 1, one-cycle pulse for a key release.
REQ-010 SHALL have port parity_err, output, 1, one-cycle pulse for a rejected frame.

Function
REQ-011 SHALL pass both PS/2 lines through SYNC_STAGES flip-flops and SHALL sample data only on a detected falling edge of synchronized ps2_clk.
REQ-012 SHALL run a frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE; frame = start 0, 8 data bits LSB first, odd parity bit, stop 1.
REQ-013 In IDLE, a sampled start bit of 1 SHALL be ignored and the FSM SHALL remain in IDLE.
REQ-014 DATA SHALL shift 8 bits using a 3-bit counter, then go to PARITY.
REQ-015 A stop bit of 0 SHALL discard the byte, pulse parity_err, and return to IDLE.
REQ-016 Outside IDLE, a 16-bit idle counter SHALL reset on each falling edge; reaching TIMEOUT_CYCLES SHALL force IDLE, drop the partial byte, and clear the prefix flags.
REQ-017 The prefix layer SHALL hold ext and brk flags; byte E0 sets ext, byte F0 sets brk, and neither prefix byte produces output.
REQ-018 Byte E1 SHALL be dropped with no output and no flag change.
REQ-019 Any other byte b SHALL load keyCode = {ext, b}, pulse make if brk = 0 or brake if brk = 1, then clear both flags.
REQ-020 Latency: with the stop-bit edge detected in cycle N, keyCode update and the make/brake pulse SHALL occur in cycle N+2.
REQ-021 make and brake SHALL never be high together and SHALL each be high for exactly one cycle per key byte.
REQ-022 keyCode SHALL hold its value until the next key byte; repeated makes from auto-repeat SHALL each pulse make.
REQ-023 A discarded byte (parity or stop error) SHALL clear ext and brk.

Reset
REQ-024 resetN low SHALL asynchronously set: FSM to IDLE, shift register, counters, ext and brk to 0, synchronizers to 1 (idle line), keyCode to 9'h000, and make, brake, parity_err to 0.
REQ-025 Reset mid-frame or mid-sequence SHALL discard all partial state, and no pulse SHALL be emitted on reset release.

Configuration
REQ-026 Macro PS2_PARITY_CHECK_EN, when defined: a parity mismatch SHALL discard the byte, pulse parity_err in cycle N+2, and clear the flags.
REQ-027 Macro PS2_PARITY_CHECK_EN, when undefined: the parity bit SHALL be sampled but ignored, and parity_err SHALL pulse only on stop-bit error.

Verification
REQ-028 Frame 8'h1C -> keyCode = 9'h01C, make high for exactly 1 cycle at N+2, brake = 0.
REQ-029 Frames F0, 1C -> no output after F0; after 1C, keyCode = 9'h01C and brake high for 1 cycle, make = 0.
REQ-030 Frames E0, 4A then E0, F0, 5A -> make with keyCode = 9'h14A, then brake with keyCode = 9'h15A.
REQ-031 Frame 8'h1C with wrong parity -> with PS2_PARITY_CHECK_EN: parity_err pulse, no make, keyCode unchanged; without it: make, keyCode = 9'h01C.
REQ-032 5 bits of a frame, then ps2_clk idle for TIMEOUT_CYCLES+10, then full frame 8'h75 -> keyCode = 9'h075 with make, no parity_err.
REQ-033 Frame E0, then resetN pulse, then frame 6C -> keyCode = 9'h06C (not 9'h16C) with make.
